// File: rtl/f11_wbm_engine.sv
// Single-transfer Wishbone master engine with slow-clock moderation,
// bus timeout with bounded retries, and abort.
module f11_wbm_engine #(
    parameter int AW     = 22,
    parameter int TMO_W  = 6,
    parameter int WCNT_W = 6,
    parameter int RETRY  = 0
) (
    input  logic          vm_clk_p,
    input  logic          vm_rst_n,
    input  logic          vm_clk_ena,
    input  logic          vm_clk_slow,
    input  logic          req_i,
    input  logic          req_we_i,
    input  logic          req_byte_i,
    input  logic          req_ios_i,
    input  logic [AW-1:0] req_adr_i,
    input  logic [15:0]   req_dat_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          rsp_ack_o,
    output logic          rsp_err_o,
    output logic [15:0]   rsp_dat_o,
    input  logic          wbm_gnt_i,
    input  logic          wbm_ack_i,
    input  logic [15:0]   wbm_dat_i,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic          wbm_ios_o,
    output logic [1:0]    wbm_sel_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [15:0]   wbm_dat_o
);

    typedef enum logic [1:0] {IDLE, WAIT, STB, GAP} state_t;

    localparam logic [2:0] RETRY_MAX = 3'(RETRY);

    state_t            state;
    state_t            state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [TMO_W-1:0]  tcnt;
    logic [2:0]        retries;
    logic              we_q;
    logic [1:0]        sel_q;
    logic              accept;
    logic              ack_done;
    logic              timeout;
    logic              tmo_retry;
    logic              tmo_fail;
    logic [1:0]        sel_in;

    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_done   = 1'b0;
        timeout    = 1'b0;
        tmo_retry  = 1'b0;
        tmo_fail   = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    accept     = 1'b1;
                    state_next = (vm_clk_slow && wcnt != '0) ? WAIT : STB;
                end
            end
            WAIT: begin
                if (wcnt == '0)
                    state_next = STB;
            end
            STB: begin
                timeout = (tcnt == '1) && !wbm_ack_i;
                if (wbm_ack_i) begin
                    ack_done   = !abort_i;
                    state_next = IDLE;
                end else if (timeout) begin
                    if (retries < RETRY_MAX) begin
                        tmo_retry  = !abort_i;
                        state_next = GAP;
                    end else begin
                        tmo_fail   = !abort_i;
                        state_next = IDLE;
                    end
                end
            end
            GAP: state_next = STB;
            default: state_next = IDLE;
        endcase
        // Abort overrides every other transition out of a busy state
        if (abort_i && state != IDLE)
            state_next = IDLE;
    end

    assign sel_in = (req_we_i && req_byte_i) ? {req_adr_i[0], ~req_adr_i[0]} : 2'b11;

    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            wcnt      <= '0;
            tcnt      <= '0;
            retries   <= '0;
            we_q      <= 1'b0;
            sel_q     <= 2'b00;
            wbm_ios_o <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_ack_o <= 1'b0;
            rsp_err_o <= 1'b0;
            rsp_dat_o <= '0;
        end else begin
            rsp_ack_o <= ack_done || tmo_fail;
            rsp_err_o <= tmo_fail;
            if (ack_done && !we_q)
                rsp_dat_o <= wbm_dat_i;

            if (accept) begin
                we_q      <= req_we_i;
                sel_q     <= sel_in;
                wbm_ios_o <= req_ios_i;
                wbm_adr_o <= req_adr_i;
                wbm_dat_o <= req_dat_i;
            end

            if (!vm_clk_slow)
                wcnt <= '0;
            else if (state == IDLE && !vm_clk_ena && wcnt != '1)
                wcnt <= wcnt + 1'b1;
            else if (state == WAIT && vm_clk_ena && wcnt != '0)
                wcnt <= wcnt - 1'b1;

            if (state_next == STB && state != STB)
                tcnt <= '0;
            else if (state == STB && wbm_gnt_i)
                tcnt <= tcnt + 1'b1;

            if (tmo_retry)
                retries <= retries + 1'b1;
            else if (state_next == IDLE || accept)
                retries <= '0;
        end
    end

    assign busy_o    = (state != IDLE);
    assign wbm_cyc_o = (state == STB);
    assign wbm_stb_o = (state == STB);
    assign wbm_we_o  = (state == STB) && we_q;
    assign wbm_sel_o = (state == STB) ? sel_q : 2'b00;

endmodule

// File: doc/f11_wbm_engine.md
F11_WBM_ENGINE -- requirements
Module: f11_wbm_engine

Interface
REQ-001 SHALL have parameter AW, default 22: bus address width.
REQ-002 SHALL have parameter TMO_W, default 6: bus timeout counter width.
REQ-003 SHALL have parameter WCNT_W, default 6: slow-clock moderator counter width.
REQ-004 SHALL have parameter RETRY, default 0: timeout retries before error, range 0..7.
REQ-005 SHALL have port vm_clk_p, input, 1: the single clock; all flops clock on its rising edge.
REQ-006 SHALL have port vm_rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports vm_clk_ena (in, 1) and vm_clk_slow (in, 1): slow-clock strobe and slow-mode select.
REQ-008 SHALL have request ports req_i (in, 1), req_we_i (in, 1), req_byte_i (in, 1), req_ios_i (in, 1), req_adr_i (in, AW) and req_dat_i (in, 16).
REQ-009 SHALL have ports abort_i (in, 1), busy_o (out, 1), rsp_ack_o (out, 1), rsp_err_o (out, 1) and rsp_dat_o (out, 16).
REQ-010 SHALL have Wishbone master ports wbm_gnt_i (in, 1), wbm_ack_i (in, 1), wbm_dat_i (in, 16), wbm_cyc_o (out, 1), wbm_stb_o (out, 1), wbm_we_o (out, 1), wbm_ios_o (out, 1), wbm_sel_o (out, 2), wbm_adr_o (out, AW) and wbm_dat_o (out, 16).

Function
REQ-011 SHALL implement states IDLE, WAIT, STB, GAP; busy_o = (state != IDLE).
REQ-012 IDLE, req_i=1 SHALL latch adr, dat, we, ios and byte lanes; next state WAIT if vm_clk_slow=1 and wcnt!=0, else STB; req_i while busy is ignored.
REQ-013 Byte lanes SHALL be sel=2'b11 for word or read; for a byte write, sel[0]=~adr[0] and sel[1]=adr[0].
REQ-014 wcnt SHALL clear when vm_clk_slow=0, and increment in IDLE when vm_clk_slow=1 and vm_clk_ena=0, saturating at all-ones.
REQ-015 In WAIT, wcnt SHALL decrement on vm_clk_ena=1; WAIT exits to STB in the cycle after wcnt reaches 0.
REQ-016 In STB, wbm_cyc_o and wbm_stb_o SHALL be 1 and wbm_we_o SHALL equal the latched we; outside STB all three and wbm_sel_o SHALL be 0.
REQ-017 wbm_adr_o, wbm_dat_o and wbm_ios_o SHALL hold the latched values from accept until the next accept.
REQ-018 On wbm_ack_i=1 in STB, the block SHALL go to IDLE at that edge, drop cyc and stb, and pulse rsp_ack_o=1 for exactly one cycle.
REQ-019 On a read ack, rsp_dat_o SHALL capture wbm_dat_i in the same edge; on a write ack, rsp_dat_o is unchanged.
REQ-020 Fast-mode latency SHALL be: req sampled at edge 0, stb high in cycle 1, ack in cycle 1 gives rsp_ack_o in cycle 2, and a new req is accepted in cycle 2.
REQ-021 tcnt SHALL increment each STB cycle with wbm_gnt_i=1 and hold while gnt=0; it clears on entry to STB.
REQ-022 In STB, tcnt at all-ones with no ack SHALL be a timeout.
REQ-023 On timeout with retries used < RETRY, the block SHALL go to GAP for 1 cycle (cyc=0), then back to STB with retries+1.
REQ-024 On timeout otherwise, the block SHALL go to IDLE and pulse rsp_ack_o and rsp_err_o together for one cycle.
REQ-025 Ack and timeout in the same cycle SHALL count as ack.
REQ-026 abort_i=1 SHALL force IDLE at the next edge, drop cyc/stb, emit no response and clear retries; abort wins over a simultaneous ack, and abort in IDLE has no effect.
REQ-027 rsp_err_o SHALL be 0 on every successful ack.

Reset
REQ-028 vm_rst_n=0 SHALL immediately force state IDLE, and set wcnt, tcnt, retries, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ios_o, wbm_sel_o, rsp_ack_o, rsp_err_o and busy_o to 0, with wbm_adr_o, wbm_dat_o and rsp_dat_o at 0.
REQ-029 Reset asserted mid-cycle SHALL drop cyc/stb asynchronously and emit no response after release.

Verification
REQ-030 Fast read, adr=22'o0177560, ack in cycle 1 with wbm_dat_i=16'o000200 -> rsp_ack_o pulse in cycle 2, rsp_dat_o=16'o000200, sel=2'b11, we=0.
REQ-031 Byte write to odd address 16'o001001 -> sel=2'b10, we=1; byte write to 16'o001000 -> sel=2'b01.
REQ-032 vm_clk_slow=1 with 5 idle cycles at vm_clk_ena=0, then req -> WAIT for exactly 5 vm_clk_ena pulses before stb rises.
REQ-033 TMO_W=3, RETRY=2, no ack -> 3 STB windows of 8 granted cycles, separated by 1-cycle GAPs, then rsp_ack_o=rsp_err_o=1.
REQ-034 abort_i in the same cycle as wbm_ack_i -> no rsp_ack_o, IDLE, and the next req is accepted normally.
REQ-035 Timeout test with wbm_gnt_i=0 for 20 cycles -> no timeout until gnt rises.
